// File: rtl/demux_pkg.sv
// Shared constants for the result demultiplexer.
// Destination encodings and the default datapath width.
package demux_pkg;
   localparam int   DEF_WIDTH = 32;
   localparam logic SEL_WB    = 1'b0;
   localparam logic SEL_MEM   = 1'b1;
endpackage

// File: rtl/demux_fifo.sv
// Per-destination synchronous FIFO used by result_demux.
// Occupancy count is the only source of full/empty.
module demux_fifo
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign head  = mem[rptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + PTR_ONE;
         end
         if (pop)
            rptr <= rptr + PTR_ONE;
         // Push and pop together leave the count unchanged.
         unique case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/result_demux.sv
// Registered 1-to-2 result demux: steers words into writeback/store FIFOs.
// Optional transfer counters cnt0/cnt1 under RESULT_DEMUX_STATS_EN.
module result_demux
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready
`ifdef RESULT_DEMUX_STATS_EN
   ,
   output logic [31:0]      cnt0,
   output logic [31:0]      cnt1
`endif
);
   logic full0, full1;
   logic empty0, empty1;
   logic push0, push1;
   logic pop0, pop1;
   logic accept;

   // No bypass: a full FIFO stalls input even while it is draining.
   assign in_ready = (in_sel == SEL_MEM) ? !full1 : !full0;
   assign accept   = in_valid && in_ready;
   assign push0    = accept && (in_sel == SEL_WB);
   assign push1    = accept && (in_sel == SEL_MEM);

   assign out0_valid = !empty0;
   assign out1_valid = !empty1;
   assign pop0       = out0_valid && out0_ready;
   assign pop1       = out1_valid && out1_ready;

   demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_wb (
      .clk   (clk),
      .reset (reset),
      .push  (push0),
      .wdata (in_data),
      .pop   (pop0),
      .full  (full0),
      .empty (empty0),
      .head  (out0_data)
   );

   demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_mem (
      .clk   (clk),
      .reset (reset),
      .push  (push1),
      .wdata (in_data),
      .pop   (pop1),
      .full  (full1),
      .empty (empty1),
      .head  (out1_data)
   );

`ifdef RESULT_DEMUX_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (pop0) cnt0 <= cnt0 + 32'd1;
         if (pop1) cnt1 <= cnt1 + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_result_demux.sv
// Directed self-checking bench for result_demux (DEPTH = 2).
// Counter checks compile only with RESULT_DEMUX_STATS_EN.
module tb_result_demux;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_data;
   logic        in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out0_data;
   logic        out0_valid;
   logic        out0_ready;
   logic [31:0] out1_data;
   logic        out1_valid;
   logic        out1_ready;
`ifdef RESULT_DEMUX_STATS_EN
   logic [31:0] cnt0;
   logic [31:0] cnt1;
`endif

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   result_demux #(.WIDTH(32), .DEPTH(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready)
`ifdef RESULT_DEMUX_STATS_EN
      ,
      .cnt0       (cnt0),
      .cnt1       (cnt1)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset      = 1'b1;
      in_data    = '0;
      in_sel     = 1'b0;
      in_valid   = 1'b0;
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
      chk("rst_v0", 32'(out0_valid), 32'd0);
      chk("rst_v1", 32'(out1_valid), 32'd0);
      chk("rst_d0", out0_data, 32'd0);
      chk("rst_d1", out1_data, 32'd0);
      chk("rst_rdy", 32'(in_ready), 32'd1);

      // single word to writeback, 1-cycle latency
      in_valid   = 1'b1;
      in_sel     = 1'b0;
      in_data    = 32'h0000_00AA;
      out0_ready = 1'b1;
      chk("t1_rdy", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("t1_v0", 32'(out0_valid), 32'd1);
      chk("t1_d0", out0_data, 32'h0000_00AA);
      chk("t1_v1", 32'(out1_valid), 32'd0);
      step();
      chk("t1_pop", 32'(out0_valid), 32'd0);

      // fill store FIFO, per-destination ready
      out1_ready = 1'b0;
      in_valid   = 1'b1;
      in_sel     = 1'b1;
      in_data    = 32'h11;
      step();
      in_data = 32'h22;
      step();
      chk("t2_full", 32'(in_ready), 32'd0);
      in_sel = 1'b0;
      #1;
      chk("t2_sel0", 32'(in_ready), 32'd1);
      in_sel  = 1'b1;
      in_data = 32'h33;
      step();
      chk("t2_hold", out1_data, 32'h11);
      chk("t2_stall", 32'(in_ready), 32'd0);

      // pop while full: no bypass
      out1_ready = 1'b1;
      #1;
      chk("t3_nobyp", 32'(in_ready), 32'd0);
      step();
      chk("t3_rdy", 32'(in_ready), 32'd1);
      chk("t3_head", out1_data, 32'h22);
      out1_ready = 1'b0;
      step();
      in_valid = 1'b0;
      chk("t3_full2", 32'(in_ready), 32'd0);
      chk("t3_d22", out1_data, 32'h22);
      out1_ready = 1'b1;
      step();
      chk("t3_d33", out1_data, 32'h33);
      chk("t3_v33", 32'(out1_valid), 32'd1);
      step();
      chk("t3_empty", 32'(out1_valid), 32'd0);

      // alternating stream, no stalls
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_sel   = (i % 2 == 0);
         in_data  = 32'(i);
         chk($sformatf("t4_rdy%0d", i), 32'(in_ready), 32'd1);
         step();
         if (i % 2 == 1) begin
            chk($sformatf("t4_v0_%0d", i), 32'(out0_valid), 32'd1);
            chk($sformatf("t4_d0_%0d", i), out0_data, 32'(i));
            chk($sformatf("t4_x1_%0d", i), 32'(out1_valid), 32'd0);
         end else begin
            chk($sformatf("t4_v1_%0d", i), 32'(out1_valid), 32'd1);
            chk($sformatf("t4_d1_%0d", i), out1_data, 32'(i));
            chk($sformatf("t4_x0_%0d", i), 32'(out0_valid), 32'd0);
         end
      end
      in_valid = 1'b0;
      step();
      chk("t4_idle0", 32'(out0_valid), 32'd0);
      chk("t4_idle1", 32'(out1_valid), 32'd0);

      // mid-operation reset discards contents
      out0_ready = 1'b0;
      in_valid   = 1'b1;
      in_sel     = 1'b0;
      in_data    = 32'h5;
      step();
      in_data = 32'h6;
      step();
      in_valid = 1'b0;
      chk("t5_pre", out0_data, 32'h5);
      chk("t5_prefull", 32'(in_ready), 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t5_v0", 32'(out0_valid), 32'd0);
      chk("t5_d0", out0_data, 32'd0);
      chk("t5_rdy0", 32'(in_ready), 32'd1);
      in_sel = 1'b1;
      #1;
      chk("t5_rdy1", 32'(in_ready), 32'd1);
      step();
      chk("t5_stale", 32'(out0_valid), 32'd0);
      chk("t5_staled", out0_data, 32'd0);

`ifdef RESULT_DEMUX_STATS_EN
      chk("s_rst0", cnt0, 32'd0);
      chk("s_rst1", cnt1, 32'd0);
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_sel   = (i >= 5);
         in_data  = 32'(i + 100);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      chk("s_cnt0", cnt0, 32'd5);
      chk("s_cnt1", cnt1, 32'd3);
      force dut.cnt0 = 32'hFFFF_FFFF;
      #1;
      release dut.cnt0;
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = 32'h77;
      step();
      in_valid = 1'b0;
      step();
      chk("s_wrap", cnt0, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/result_demux.md
# result_demux

Registered 1-to-2 result demultiplexer for the MIPS datapath. It accepts one word per cycle on a valid/ready input and steers it by `in_sel` into one of two independent per-destination FIFOs: destination 0 is register writeback, destination 1 is store data. It is the distribution end of the operand-select path: it fans a single result stream out to two consumers, where the existing multiplexers merge two sources into one.

## Interface
Parameters:
- `WIDTH`, 32: data width of input and both outputs.
- `DEPTH`, 2: entries per destination FIFO; power of two, ≥ 2.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high reset.
- `in_data` input WIDTH: result word.
- `in_sel` input 1: destination; 0 = writeback (out0), 1 = store (out1).
- `in_valid` input 1: `in_data`/`in_sel` valid.
- `in_ready` output 1: block can accept the word for the currently presented `in_sel`.
- `out0_data` output WIDTH: head of FIFO 0.
- `out0_valid` output 1: FIFO 0 not empty.
- `out0_ready` input 1: consumer 0 takes head.
- `out1_data`, `out1_valid`, `out1_ready`: same as above, for FIFO 1.
- `cnt0`, `cnt1` output 32: transfer counters. Present only with `RESULT_DEMUX_STATS_EN`.

## Operation
- Input transfer occurs when `in_valid && in_ready`. The word is enqueued into FIFO[`in_sel`] only; the other FIFO is untouched.
- `in_ready = !full[in_sel]`. This is a combinational function of `in_sel` and registered occupancy only, never of `in_valid` or the `outN_ready` inputs.
- There is no full-FIFO bypass. If the selected FIFO is full, input stalls even when that FIFO is dequeuing in the same cycle.
- Output transfer on FIFO N occurs when `outN_valid && outN_ready`. The head is popped.
- Each FIFO has a write pointer, a read pointer and an occupancy count.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - The count is log2(DEPTH)+1 bits and is the sole source of full (count == DEPTH) and empty (count == 0).
- Simultaneous push and pop on the same FIFO:
  - Count is unchanged.
  - Both pointers advance.
  - Legal only when not full (see no-bypass rule above).
- Pop on an empty FIFO is impossible because valid is low. A push while the selected FIFO is full is prevented because ready is low.
- Ordering:
  - Strict FIFO order within each destination.
  - No ordering relation between destinations. out1 may drain while out0 is stalled, and the reverse.
- `in_sel` has no effect while `in_valid` is low.
- `in_data` and `in_sel` must be held stable while `in_valid && !in_ready`.
- Reset, including mid-operation:
  - All pointers, counts and storage are cleared; stored contents are discarded.
  - Afterwards `out0_valid = out1_valid = 0`, `out0_data = out1_data = 0`, and `in_ready = 1`.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears on `outN_data`/`outN_valid` after edge N, i.e. during cycle N+1.
- Throughput is one input per cycle, sustained when the selected consumer holds `ready` high and DEPTH ≥ 2.
- `outN_valid` and `outN_data` are driven from registers and storage only, with no combinational path from the inputs.
- `in_ready` depends combinationally only on `in_sel`.
- Reset takes effect at the first posedge with `reset` high. Outputs are at reset values from that edge on.

## Configuration
- Macro `RESULT_DEMUX_STATS_EN` defined:
  - `cnt0`/`cnt1` exist.
  - Each increments by 1 on every output transfer on its port.
  - Each wraps from 0xFFFFFFFF to 0.
  - Both clear to 0 on reset.
- Macro undefined: the ports and counter logic are absent. Datapath behaviour is identical either way.

## Structure
- Shared package `demux_pkg` holds:
  - Default `WIDTH` = 32.
  - Destination constants `SEL_WB = 1'b0` and `SEL_MEM = 1'b1`.
- Sub-module `demux_fifo`:
  - Synchronous FIFO of WIDTH × DEPTH with push/pop/full/empty/head.
  - Instantiated twice.
- The top level holds the steering, the ready logic and the optional counters.

## Test plan
- Reset, then `in_valid = 1`, `in_sel = 0`, `in_data = 0x0000_00AA`, `out0_ready = 1` → `out0_valid = 1`, `out0_data = 0xAA` in the next cycle; `out1_valid` stays 0.
- `out1_ready = 0`, push 0x11, 0x22 with `in_sel = 1` (DEPTH = 2) → `in_ready` goes 0 for `in_sel = 1` but is 1 for `in_sel = 0`. A third push with `in_sel = 1` is held until one pop, then 0x11, 0x22, 0x33 drain in order.
- FIFO 1 full, `out1_ready = 1` and `in_valid = 1` with `in_sel = 1` in the same cycle → pop occurs, push does not (`in_ready = 0`). The push is accepted the following cycle.
- Stream 0x1..0x8 alternating `in_sel` with both readies high → zero stall cycles. out0 sees 1, 3, 5, 7 and out1 sees 2, 4, 6, 8, each 1 cycle after acceptance.
- Push 0x5 and 0x6 to FIFO 0, assert `reset` for one cycle with `out0_ready = 0` → after that edge `out0_valid = 0`, `out0_data = 0`, `in_ready = 1`; no stale words appear after release.
- With `RESULT_DEMUX_STATS_EN`: 5 transfers on out0 and 3 on out1 → `cnt0 = 5`, `cnt1 = 3`. Preload by forcing 0xFFFFFFFF, one transfer → 0.
